i2c_page_wr_master: RTL and testbench
=====================================

// Module: i2c_page_wr_master
// PURPOSE
// - I2C master write engine for the EEPROM path; drains the 8-bit FWFT TX FIFO that sits directly upstream.
// - On a start pulse it issues, in order: START, device address + W, word address (ADDR_BYTES bytes),
//   byte_cnt data bytes popped from the FIFO, then STOP.
// - Reports completion (done) and any NACK (ack_err). SDA is open-drain; SCL is push-pull (no slave clock stretching).
// PARAMETERS
// - SYS_CLK_FREQ  50_000_000  sys_clk frequency, Hz.
// - SCL_FREQ      250_000     SCL frequency, Hz.
// - ADDR_BYTES    2           number of word-address bytes; legal values 1 or 2. For 1, only word_addr[7:0] is sent.
// - PAGE_SIZE     32          maximum data bytes per transaction.
// - Derived: QTR = SYS_CLK_FREQ/(4*SCL_FREQ), which is 50 at the defaults. One SCL bit = 4 quarter phases.
// PORTS
// - sys_clk     in   1   system clock.
// - sys_rst_n   in   1   asynchronous reset, active-low.
// - start       in   1   one-cycle request; ignored while busy=1.
// - dev_addr    in   7   7-bit slave address; latched on an accepted start.
// - word_addr   in   16  EEPROM word address; latched on an accepted start.
// - byte_cnt    in   6   data bytes to write; latched on an accepted start. Values above PAGE_SIZE saturate to PAGE_SIZE.
// - fifo_dout   in   8   FIFO head byte; valid whenever fifo_empty=0 (FWFT).
// - fifo_empty  in   1   FIFO empty flag.
// - fifo_rd_en  out  1   one-cycle pop strobe.
// - sda_i       in   1   sampled SDA line.
// - sda_oe      out  1   1 pulls SDA low; 0 releases SDA (high via pull-up).
// - scl         out  1   SCL.
// - busy        out  1   high from the cycle after an accepted start until done.
// - done        out  1   one-cycle pulse at the end of a transaction.
// - ack_err     out  1   valid with done; 1 means a NACK was received. Holds until the next accepted start.
// BEHAVIOUR
// - Reset values: scl=1, sda_oe=0, fifo_rd_en=0, busy=0, done=0, ack_err=0, FSM in IDLE.
// - Reset taking effect mid-transaction: outputs return to reset values immediately, with no STOP generated.
// - Timing base: a counter 0..QTR-1 produces a quarter tick; a phase counter runs 0..3 within each bit.
//   - ph0: SCL low; SDA updated.
//   - ph1: SCL rises.
//   - ph2: SDA sampled, SCL high.
//   - ph3: SCL falls.
// - FSM states: IDLE -> START -> DEV -> DEV_ACK -> ADDR_H (skipped if ADDR_BYTES=1) -> AH_ACK -> ADDR_L -> AL_ACK
//   -> DATA -> D_ACK -> STOP -> DONE -> IDLE.
// - START: SDA is released with SCL high for 1 quarter, then pulled low for 1 quarter, then SCL goes low.
// - STOP: SDA low, SCL rises, then after 1 quarter SDA is released; 2 more quarters of bus-free time follow.
// - Byte transmission: MSB first, 8 bits; the ACK bit has SDA released and is sampled at ph2. sda_i=1 means NACK.
// - Any NACK: set ack_err=1 and go to STOP. No further FIFO pops occur.
// - Device byte = {dev_addr, 1'b0}.
// - Data load: in the cycle the FSM enters DATA and fifo_empty=0, shift_reg<=fifo_dout and fifo_rd_en=1 for
//   exactly 1 cycle. Exactly one pop per data byte sent.
// - FIFO empty when a data byte is due: hold SCL low and SDA unchanged, pause the quarter counter, and wait.
//   Resume with a normal ph0 in the cycle after fifo_empty drops.
// - byte_cnt=0 (after saturation): after AL_ACK go straight to STOP. This is an address-only dummy write; no pops occur.
// - Remaining-byte counter: 6 bits, decremented at each D_ACK; STOP follows when it reaches 0.
// - done pulses in the DONE state; busy falls in the same cycle.
// - A start arriving in the same cycle as done is ignored.
// TESTING
// - Write dev=0x50, addr=0x0123, cnt=3, FIFO {0xA5,0x5A,0xFF}, all ACK -> bus bytes A0,01,23,A5,5A,FF; 3 pops;
//   done=1 with ack_err=0; SCL period = 200 clocks.
// - NACK on the device byte (sda_i=1 at DEV_ACK ph2) -> STOP immediately; 0 pops; done=1 with ack_err=1.
// - cnt=2, FIFO loaded with 1 byte -> SCL held low after the 1st D_ACK; pushing 0x77 resumes; the 2nd byte on the
//   bus is 0x77; 2 pops total.
// - cnt=40 -> saturates to 32 data bytes, 32 pops; cnt=0 -> bus bytes A0,01,23 then STOP, 0 pops.
// - ADDR_BYTES=1 with addr=0x01AB -> address phase sends only 0xAB.
// - Assert sys_rst_n low mid-DATA -> next cycle scl=1, sda_oe=0, busy=0; a new start after reset runs a clean
//   transaction. A second start during busy is ignored.

Source files
------------

// File: rtl/i2c_page_wr_master.sv
// i2c_page_wr_master
// I2C master write engine for the EEPROM path. On an accepted start it sends
// START, {dev_addr,W}, ADDR_BYTES word-address bytes, byte_cnt data bytes
// popped from the upstream FWFT FIFO, then STOP, and reports done/ack_err.
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   start                one-cycle request (ignored while busy)
//   dev_addr/word_addr/byte_cnt  transaction descriptor, latched on start
//   fifo_dout/fifo_empty/fifo_rd_en  FWFT FIFO head, empty flag, pop strobe
//   sda_i/sda_oe         sampled SDA, open-drain pull-down enable
//   scl                  push-pull SCL
//   busy/done/ack_err    status
module i2c_page_wr_master #(
  parameter int unsigned SYS_CLK_FREQ = 50_000_000,
  parameter int unsigned SCL_FREQ     = 250_000,
  parameter int unsigned ADDR_BYTES   = 2,
  parameter int unsigned PAGE_SIZE    = 32
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [6:0]  dev_addr,
  input  logic [15:0] word_addr,
  input  logic [5:0]  byte_cnt,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        scl,
  output logic        busy,
  output logic        done,
  output logic        ack_err
);

  localparam int unsigned QTR = SYS_CLK_FREQ / (4 * SCL_FREQ);
  localparam int unsigned QW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QTR_LAST = QW'(QTR - 1);
  localparam logic [5:0]    PAGE_MAX = 6'(PAGE_SIZE);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV, S_DEV_ACK, S_ADDR_H, S_AH_ACK,
    S_ADDR_L, S_AL_ACK, S_DATA, S_D_ACK, S_STOP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [5:0]    rem_q, rem_d;
  logic [6:0]    dev_q, dev_d;
  logic [15:0]   addr_q, addr_d;
  logic          need_load_q, need_load_d;
  logic          ack_err_q, ack_err_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;

  logic tick, bit_end, scl_bit;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      qcnt_q      <= '0;
      phase_q     <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      rem_q       <= '0;
      dev_q       <= '0;
      addr_q      <= '0;
      need_load_q <= 1'b0;
      ack_err_q   <= 1'b0;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      phase_q     <= phase_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      rem_q       <= rem_d;
      dev_q       <= dev_d;
      addr_q      <= addr_d;
      need_load_q <= need_load_d;
      ack_err_q   <= ack_err_d;
      scl_q       <= scl_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    phase_d     = phase_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    rem_d       = rem_q;
    dev_d       = dev_q;
    addr_d      = addr_q;
    need_load_d = need_load_q;
    ack_err_d   = ack_err_q;
    scl_d       = 1'b1;
    sda_oe_d    = 1'b0;
    fifo_rd_en  = 1'b0;

    tick    = (qcnt_q == QTR_LAST);
    bit_end = tick && (phase_q == 2'd3);
    scl_bit = (phase_q == 2'd1) || (phase_q == 2'd2);

    // Quarter timer free-runs in every active state; IDLE, DONE and the
    // FIFO-wait hold override it below.
    if (tick) begin
      qcnt_d  = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      qcnt_d  = qcnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        qcnt_d  = '0;
        phase_d = '0;
        if (start) begin
          dev_d     = dev_addr;
          addr_d    = word_addr;
          rem_d     = (byte_cnt > PAGE_MAX) ? PAGE_MAX : byte_cnt;
          ack_err_d = 1'b0;
          state_d   = S_START;
        end
      end

      S_START: begin
        scl_d    = (phase_q < 2'd2);
        sda_oe_d = (phase_q != 2'd0);
        if (bit_end) begin
          shift_d  = {dev_q, 1'b0};
          bitcnt_d = '0;
          state_d  = S_DEV;
        end
      end

      S_DEV, S_ADDR_H, S_ADDR_L, S_DATA: begin
        if (state_q == S_DATA && need_load_q) begin
          // Byte due but nothing to send: freeze the bus with SCL low and
          // restart the bit at ph0 once the head byte has been taken.
          qcnt_d   = '0;
          phase_d  = '0;
          scl_d    = 1'b0;
          sda_oe_d = sda_oe_q;
          if (!fifo_empty) begin
            fifo_rd_en  = 1'b1;
            shift_d     = fifo_dout;
            need_load_d = 1'b0;
          end
        end else begin
          scl_d    = scl_bit;
          sda_oe_d = ~shift_q[7];
          if (bit_end) begin
            shift_d  = {shift_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              case (state_q)
                S_DEV:    state_d = S_DEV_ACK;
                S_ADDR_H: state_d = S_AH_ACK;
                S_ADDR_L: state_d = S_AL_ACK;
                default:  state_d = S_D_ACK;
              endcase
            end
          end
        end
      end

      S_DEV_ACK, S_AH_ACK, S_AL_ACK, S_D_ACK: begin
        scl_d = scl_bit;
        if (tick && phase_q == 2'd2 && sda_i) ack_err_d = 1'b1;
        if (state_q == S_D_ACK && bit_end) rem_d = rem_q - 6'd1;
        if (bit_end) begin
          bitcnt_d = '0;
          if (ack_err_q) begin
            state_d = S_STOP;
          end else begin
            case (state_q)
              S_DEV_ACK: begin
                shift_d = (ADDR_BYTES == 2) ? addr_q[15:8] : addr_q[7:0];
                state_d = (ADDR_BYTES == 2) ? S_ADDR_H : S_ADDR_L;
              end
              S_AH_ACK: begin
                shift_d = addr_q[7:0];
                state_d = S_ADDR_L;
              end
              S_AL_ACK: begin
                need_load_d = (rem_q != 6'd0);
                state_d     = (rem_q != 6'd0) ? S_DATA : S_STOP;
              end
              default: begin
                need_load_d = (rem_q != 6'd1);
                state_d     = (rem_q != 6'd1) ? S_DATA : S_STOP;
              end
            endcase
          end
        end
      end

      S_STOP: begin
        scl_d    = (phase_q != 2'd0);
        sda_oe_d = (phase_q < 2'd2);
        if (bit_end) state_d = S_DONE;
      end

      S_DONE: begin
        qcnt_d  = '0;
        phase_d = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign scl     = scl_q;
  assign sda_oe  = sda_oe_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done    = (state_q == S_DONE);
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_page_wr_master.sv
// Testbench for i2c_page_wr_master: FIFO model, I2C slave/bus monitor and a
// byte scoreboard. Two instances (2-byte and 1-byte word address) share the
// bus model through a select mux; both run with a quarter of 10 clocks.
module tb_i2c_page_wr_master;

  localparam int unsigned QTR = 10;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        start;
  logic [6:0]  dev_addr;
  logic [15:0] word_addr;
  logic [5:0]  byte_cnt;
  logic        sel;

  always #5 sys_clk = ~sys_clk;

  // FIFO model: tasks write mem/wr_ptr, the pop process writes rd_ptr
  logic [7:0]  mem [0:255];
  logic [15:0] wr_ptr = '0;
  logic [15:0] rd_ptr = '0;
  int          pop_cnt = 0;
  int          underflow = 0;
  logic        fifo_empty_m;
  logic [7:0]  fifo_dout;
  assign fifo_empty_m = (wr_ptr == rd_ptr);
  assign fifo_dout    = mem[rd_ptr[7:0]];

  // per-instance wires and mux
  logic start0, start1, fe0, fe1;
  logic rd0, rd1, oe0, oe1, scl0, scl1, busy0, busy1, done0, done1, ae0, ae1;
  logic rd_m, sda_oe_m, scl_m, busy_m, done_m, ack_err_m;
  logic slave_pull = 1'b0;
  logic line;

  assign start0    = start & ~sel;
  assign start1    = start & sel;
  assign fe0       = fifo_empty_m | sel;
  assign fe1       = fifo_empty_m | ~sel;
  assign rd_m      = sel ? rd1   : rd0;
  assign sda_oe_m  = sel ? oe1   : oe0;
  assign scl_m     = sel ? scl1  : scl0;
  assign busy_m    = sel ? busy1 : busy0;
  assign done_m    = sel ? done1 : done0;
  assign ack_err_m = sel ? ae1   : ae0;
  assign line      = ~(oe0 | oe1 | slave_pull);

  i2c_page_wr_master #(.SYS_CLK_FREQ(50_000_000), .SCL_FREQ(1_250_000),
                       .ADDR_BYTES(2), .PAGE_SIZE(32)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start0),
    .dev_addr(dev_addr), .word_addr(word_addr), .byte_cnt(byte_cnt),
    .fifo_dout(fifo_dout), .fifo_empty(fe0), .fifo_rd_en(rd0),
    .sda_i(line), .sda_oe(oe0), .scl(scl0), .busy(busy0), .done(done0),
    .ack_err(ae0));

  i2c_page_wr_master #(.SYS_CLK_FREQ(50_000_000), .SCL_FREQ(1_250_000),
                       .ADDR_BYTES(1), .PAGE_SIZE(32)) dut_a1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start1),
    .dev_addr(dev_addr), .word_addr(word_addr), .byte_cnt(byte_cnt),
    .fifo_dout(fifo_dout), .fifo_empty(fe1), .fifo_rd_en(rd1),
    .sda_i(line), .sda_oe(oe1), .scl(scl1), .busy(busy1), .done(done1),
    .ack_err(ae1));

  always @(posedge sys_clk) begin
    if (rd_m) begin
      rd_ptr  <= rd_ptr + 16'd1;
      pop_cnt <= pop_cnt + 1;
      if (fifo_empty_m) underflow <= underflow + 1;
    end
  end

  // Slave + bus monitor, sampled on the falling sys_clk edge
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int nack_idx = -1;
  int cyc = 0, rise_prev = 0, rise_last = 0, start_cnt = 0, stop_cnt = 0;
  int byte_idx = 0, bitn = 0;
  logic [7:0] sh = '0;
  logic in_frame = 1'b0, prev_scl = 1'b1, prev_line = 1'b1, cur_line;

  initial begin
    forever begin
      @(negedge sys_clk);
      cyc++;
      cur_line = line;
      if (prev_scl && scl_m && prev_line && !cur_line) begin
        in_frame = 1'b1; bitn = 0; byte_idx = 0; slave_pull = 1'b0;
        start_cnt++;
      end else if (prev_scl && scl_m && !prev_line && cur_line) begin
        in_frame = 1'b0; bitn = 0; stop_cnt++;
      end else if (!prev_scl && scl_m) begin
        rise_prev = rise_last; rise_last = cyc;
        if (in_frame) begin
          if (bitn < 8) begin
            sh = {sh[6:0], cur_line};
            bitn++;
            if (bitn == 8) obs_q.push_back(sh);
          end else if (bitn == 8) begin
            bitn = 9;
          end
        end
      end else if (prev_scl && !scl_m && in_frame) begin
        if (bitn == 8) begin
          slave_pull = (byte_idx != nack_idx);
        end else if (bitn == 9) begin
          slave_pull = 1'b0; bitn = 0; byte_idx++;
        end
      end
      prev_scl  = scl_m;
      prev_line = cur_line;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 16'd1;
  endtask

  task automatic flush_fifo();
    wr_ptr = rd_ptr;
  endtask

  task automatic start_txn(input logic [6:0] d, input logic [15:0] a, input logic [5:0] c);
    @(negedge sys_clk);
    dev_addr = d; word_addr = a; byte_cnt = c; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge sys_clk);
      if (done_m) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; start = 1'b0; sel = 1'b0;
    dev_addr = '0; word_addr = '0; byte_cnt = '0;
    repeat (3) @(negedge sys_clk);
    checks++; if (scl_m !== 1'b1)     begin failures++; $display("FAIL reset_scl got %b exp 1", scl_m); end
    checks++; if (sda_oe_m !== 1'b0)  begin failures++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe_m); end
    checks++; if (busy_m !== 1'b0)    begin failures++; $display("FAIL reset_busy got %b exp 0", busy_m); end
    checks++; if (done_m !== 1'b0)    begin failures++; $display("FAIL reset_done got %b exp 0", done_m); end
    checks++; if (ack_err_m !== 1'b0) begin failures++; $display("FAIL reset_ack_err got %b exp 0", ack_err_m); end
    checks++; if (rd_m !== 1'b0)      begin failures++; $display("FAIL reset_rd_en got %b exp 0", rd_m); end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_write();
    bit ok; int p0, s0; logic [7:0] e, o;
    exp_q.delete(); obs_q.delete(); p0 = pop_cnt; s0 = stop_cnt;
    push_byte(8'hA5); push_byte(8'h5A); push_byte(8'hFF);
    exp_q = '{8'hA0, 8'h01, 8'h23, 8'hA5, 8'h5A, 8'hFF};
    start_txn(7'h50, 16'h0123, 6'd3);
    checks++; if (busy_m !== 1'b1) begin failures++; $display("FAIL write_busy got %b exp 1", busy_m); end
    wait_done(5000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL write_timeout got no done exp done"); end
    checks++; if (ack_err_m !== 1'b0) begin failures++; $display("FAIL write_ack_err got %b exp 0", ack_err_m); end
    checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL write_busy_at_done got %b exp 0", busy_m); end
    // start coinciding with done must be dropped
    dev_addr = 7'h11; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    checks++; if (done_m !== 1'b0) begin failures++; $display("FAIL done_pulse got %b exp 0", done_m); end
    checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL start_on_done got busy %b exp 0", busy_m); end
    checks++; if (pop_cnt - p0 !== 3) begin failures++; $display("FAIL write_pops got %0d exp 3", pop_cnt - p0); end
    checks++; if (stop_cnt - s0 !== 1) begin failures++; $display("FAIL write_stop got %0d exp 1", stop_cnt - s0); end
    checks++; if (rise_last - rise_prev !== 4 * QTR) begin failures++; $display("FAIL scl_period got %0d exp %0d", rise_last - rise_prev, 4 * QTR); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL write_byte got none exp %02h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL write_byte got %02h exp %02h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL write_extra got %0d exp 0", obs_q.size()); end
  endtask

  task automatic test_nack_dev();
    bit ok; int p0; logic [7:0] e, o;
    exp_q.delete(); obs_q.delete(); p0 = pop_cnt; nack_idx = 0;
    push_byte(8'h12); push_byte(8'h34);
    exp_q.push_back(8'hA0);
    start_txn(7'h50, 16'h0123, 6'd2);
    wait_done(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL nack_timeout got no done exp done"); end
    checks++; if (ack_err_m !== 1'b1) begin failures++; $display("FAIL nack_ack_err got %b exp 1", ack_err_m); end
    checks++; if (pop_cnt - p0 !== 0) begin failures++; $display("FAIL nack_pops got %0d exp 0", pop_cnt - p0); end
    repeat (5) @(negedge sys_clk);
    checks++; if (ack_err_m !== 1'b1) begin failures++; $display("FAIL nack_hold got %b exp 1", ack_err_m); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL nack_byte got none exp %02h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL nack_byte got %02h exp %02h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL nack_extra got %0d exp 0", obs_q.size()); end
    nack_idx = -1;
    flush_fifo();
  endtask

  task automatic test_fifo_stall();
    bit ok; int p0, hi, wt; logic [7:0] e, o;
    exp_q.delete(); obs_q.delete(); p0 = pop_cnt;
    push_byte(8'h11);
    exp_q = '{8'hA0, 8'h01, 8'h23, 8'h11, 8'h77};
    start_txn(7'h50, 16'h0123, 6'd2);
    wt = 0;
    while (obs_q.size() < 4 && wt < 4000) begin @(negedge sys_clk); wt++; end
    checks++; if (wt >= 4000) begin failures++; $display("FAIL stall_reach got %0d bytes exp 4", obs_q.size()); end
    repeat (100) @(negedge sys_clk);
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (scl_m !== 1'b0 || busy_m !== 1'b1) hi++;
    end
    checks++; if (hi !== 0) begin failures++; $display("FAIL stall_scl_low got %0d bad cycles exp 0", hi); end
    checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL stall_bytes got %0d exp 4", obs_q.size()); end
    checks++; if (pop_cnt - p0 !== 1) begin failures++; $display("FAIL stall_pops got %0d exp 1", pop_cnt - p0); end
    push_byte(8'h77);
    wait_done(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got no done exp done"); end
    checks++; if (ack_err_m !== 1'b0) begin failures++; $display("FAIL stall_ack_err got %b exp 0", ack_err_m); end
    checks++; if (pop_cnt - p0 !== 2) begin failures++; $display("FAIL stall_pops_total got %0d exp 2", pop_cnt - p0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL stall_byte got none exp %02h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL stall_byte got %02h exp %02h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL stall_extra got %0d exp 0", obs_q.size()); end
  endtask

  task automatic test_saturate();
    bit ok; int p0; logic [7:0] b, e, o;
    exp_q.delete(); obs_q.delete(); p0 = pop_cnt;
    exp_q = '{8'hA0, 8'h01, 8'h23};
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 255));
      push_byte(b);
      if (i < 32) exp_q.push_back(b);
    end
    start_txn(7'h50, 16'h0123, 6'd40);
    wait_done(20000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL sat_timeout got no done exp done"); end
    checks++; if (pop_cnt - p0 !== 32) begin failures++; $display("FAIL sat_pops got %0d exp 32", pop_cnt - p0); end
    checks++; if (wr_ptr - rd_ptr !== 16'd8) begin failures++; $display("FAIL sat_left got %0d exp 8", wr_ptr - rd_ptr); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL sat_byte got none exp %02h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL sat_byte got %02h exp %02h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL sat_extra got %0d exp 0", obs_q.size()); end
    flush_fifo();
  endtask

  task automatic test_zero();
    bit ok; int p0, s0; logic [7:0] e, o;
    exp_q.delete(); obs_q.delete(); p0 = pop_cnt; s0 = stop_cnt;
    push_byte(8'hEE);
    exp_q = '{8'hA0, 8'h01, 8'h23};
    start_txn(7'h50, 16'h0123, 6'd0);
    wait_done(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero_timeout got no done exp done"); end
    checks++; if (pop_cnt - p0 !== 0) begin failures++; $display("FAIL zero_pops got %0d exp 0", pop_cnt - p0); end
    checks++; if (stop_cnt - s0 !== 1) begin failures++; $display("FAIL zero_stop got %0d exp 1", stop_cnt - s0); end
    checks++; if (ack_err_m !== 1'b0) begin failures++; $display("FAIL zero_ack_err got %b exp 0", ack_err_m); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL zero_byte got none exp %02h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL zero_byte got %02h exp %02h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL zero_extra got %0d exp 0", obs_q.size()); end
    flush_fifo();
  endtask

  task automatic test_addr1();
    bit ok; int p0; logic [7:0] e, o;
    exp_q.delete(); obs_q.delete(); p0 = pop_cnt;
    @(negedge sys_clk);
    sel = 1'b1;
    push_byte(8'h3C);
    exp_q = '{8'hA0, 8'hAB, 8'h3C};
    start_txn(7'h50, 16'h01AB, 6'd1);
    wait_done(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL a1_timeout got no done exp done"); end
    checks++; if (pop_cnt - p0 !== 1) begin failures++; $display("FAIL a1_pops got %0d exp 1", pop_cnt - p0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL a1_byte got none exp %02h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL a1_byte got %02h exp %02h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL a1_extra got %0d exp 0", obs_q.size()); end
    @(negedge sys_clk);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok; int p0, s0, wt, bad; logic [7:0] e, o;
    p0 = pop_cnt;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    start_txn(7'h50, 16'h0123, 6'd4);
    wt = 0;
    while (pop_cnt == p0 && wt < 3000) begin @(negedge sys_clk); wt++; end
    checks++; if (wt >= 3000) begin failures++; $display("FAIL rmid_reach got %0d pops exp 1", pop_cnt - p0); end
    repeat (30) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    checks++; if (scl_m !== 1'b1)    begin failures++; $display("FAIL rmid_scl got %b exp 1", scl_m); end
    checks++; if (sda_oe_m !== 1'b0) begin failures++; $display("FAIL rmid_sda_oe got %b exp 0", sda_oe_m); end
    checks++; if (busy_m !== 1'b0)   begin failures++; $display("FAIL rmid_busy got %b exp 0", busy_m); end
    sys_rst_n = 1'b1;
    flush_fifo();
    @(negedge sys_clk);
    exp_q.delete(); obs_q.delete(); p0 = pop_cnt; s0 = start_cnt;
    push_byte(8'hC3);
    exp_q = '{8'hA0, 8'h00, 8'h40, 8'hC3};
    start_txn(7'h50, 16'h0040, 6'd1);
    repeat (500) @(negedge sys_clk);
    start_txn(7'h7F, 16'hFFFF, 6'd5);
    wait_done(5000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout got no done exp done"); end
    checks++; if (ack_err_m !== 1'b0) begin failures++; $display("FAIL rmid_ack_err got %b exp 0", ack_err_m); end
    checks++; if (pop_cnt - p0 !== 1) begin failures++; $display("FAIL rmid_pops got %0d exp 1", pop_cnt - p0); end
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL rmid_starts got %0d exp 1", start_cnt - s0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL rmid_byte got none exp %02h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL rmid_byte got %02h exp %02h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rmid_extra got %0d exp 0", obs_q.size()); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (busy_m !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rmid_idle got %0d busy cycles exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_nack_dev();
    test_fifo_stall();
    test_saturate();
    test_zero();
    test_addr1();
    test_reset_mid();
    checks++; if (underflow !== 0) begin failures++; $display("FAIL fifo_underflow got %0d exp 0", underflow); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
